// File: rtl/imc_array_sequencer.sv
// Phase sequencer for the 16x16 in-memory-compute SRAM macro: expands one-cycle
// WRITE/COMPUTE/READ commands into registered control waveforms and returns results.
module imc_array_sequencer #(
    parameter int unsigned PRE_CYC  = 2,
    parameter int unsigned EVAL_CYC = 2,
    parameter int unsigned SA_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cntrl_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_row,
    input  logic [15:0] cmd_data,
    output logic        PRE_SRAM,
    output logic        PRE_VLSA,
    output logic        PRE_CLSA,
    output logic        PRE_A,
    output logic        WE,
    output logic        EN,
    output logic        SAEN,
    output logic [15:0] WWL,
    output logic [15:0] RWL,
    output logic [15:0] RWLB,
    output logic [15:0] Din,
    input  logic [63:0] adc_in,
    input  logic [15:0] sa_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_EVAL    = 3'd3,
        ST_SENSE   = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [3:0] PRE_LOAD   = 4'(PRE_CYC - 1);
    localparam logic [3:0] EVAL_LOAD  = 4'(EVAL_CYC - 1);
    localparam logic [3:0] SA_LOAD    = 4'(SA_CYC - 1);
    localparam logic [3:0] WRITE_LOAD = 4'd1;

    function automatic logic [15:0] onehot16(input logic [3:0] row);
        return 16'h0001 << row;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [1:0]  op_r, op_sel_s;
    logic [3:0]  row_r;
    logic [15:0] data_r;
    logic        accept_s;

    logic        cmd_ready_s, busy_s, rsp_valid_s;
    logic        pre_sram_s, pre_vlsa_s, pre_clsa_s, pre_a_s, we_s, en_s, saen_s;
    logic [15:0] wwl_s, rwl_s, rwlb_s, din_s;

    // cmd_ready is only ever high in IDLE, and the synchronous clear blocks acceptance
    assign accept_s = cmd_valid & cmd_ready & ~cntrl_reset;
    // PRE outputs are decoded on the acceptance edge, before op_r holds the new opcode
    assign op_sel_s = accept_s ? cmd_op : op_r;

    // Next-state and phase-counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (cntrl_reset) begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (cmd_op != OP_NOP)) begin
                        state_s = ST_PRE;
                        cnt_s   = PRE_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_s = cnt_r - 4'd1;
                    end else if (op_r == OP_WRITE) begin
                        state_s = ST_WRITE;
                        cnt_s   = WRITE_LOAD;
                    end else begin
                        state_s = ST_EVAL;
                        cnt_s   = EVAL_LOAD;
                    end
                end
                ST_WRITE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_s = cnt_r - 4'd1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    if (cnt_r != 4'd0) begin
                        cnt_s = cnt_r - 4'd1;
                    end else begin
                        state_s = ST_SENSE;
                        cnt_s   = SA_LOAD;
                    end
                end
                ST_SENSE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_s = cnt_r - 4'd1;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: state_s = ST_RESP;
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RESP;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Moore decode of the next state, registered below so outputs line up with the state
    always_comb begin
        cmd_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        pre_sram_s  = 1'b0;
        pre_vlsa_s  = 1'b0;
        pre_clsa_s  = 1'b0;
        pre_a_s     = 1'b0;
        we_s        = 1'b0;
        en_s        = 1'b0;
        saen_s      = 1'b0;
        wwl_s       = 16'h0000;
        rwl_s       = 16'h0000;
        rwlb_s      = 16'h0000;
        din_s       = 16'h0000;
        busy_s      = (state_s != ST_IDLE);
        case (state_s)
            ST_IDLE: cmd_ready_s = 1'b1;
            ST_PRE: begin
                pre_sram_s = 1'b1;
                if (op_sel_s != OP_WRITE) begin
                    pre_vlsa_s = 1'b1;
                    pre_clsa_s = 1'b1;
                    pre_a_s    = 1'b1;
                end else begin
                    pre_vlsa_s = 1'b0;
                    pre_clsa_s = 1'b0;
                    pre_a_s    = 1'b0;
                end
            end
            ST_WRITE: begin
                wwl_s = onehot16(row_r);
                we_s  = 1'b1;
                din_s = data_r;
            end
            ST_EVAL, ST_SENSE: begin
                if (op_r == OP_READ) begin
                    rwl_s  = onehot16(row_r);
                    rwlb_s = 16'h0000;
                end else begin
                    rwl_s  = data_r;
                    rwlb_s = ~data_r;
                end
                en_s   = 1'b1;
                saen_s = (state_s == ST_SENSE);
            end
            ST_CAPTURE: cmd_ready_s = 1'b0;
            ST_RESP:    rsp_valid_s = 1'b1;
            default:    cmd_ready_s = 1'b0;
        endcase
    end

    // State, phase counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            PRE_SRAM  <= 1'b0;
            PRE_VLSA  <= 1'b0;
            PRE_CLSA  <= 1'b0;
            PRE_A     <= 1'b0;
            WE        <= 1'b0;
            EN        <= 1'b0;
            SAEN      <= 1'b0;
            WWL       <= 16'h0000;
            RWL       <= 16'h0000;
            RWLB      <= 16'h0000;
            Din       <= 16'h0000;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            cmd_ready <= cmd_ready_s;
            busy      <= busy_s;
            rsp_valid <= rsp_valid_s;
            PRE_SRAM  <= pre_sram_s;
            PRE_VLSA  <= pre_vlsa_s;
            PRE_CLSA  <= pre_clsa_s;
            PRE_A     <= pre_a_s;
            WE        <= we_s;
            EN        <= en_s;
            SAEN      <= saen_s;
            WWL       <= wwl_s;
            RWL       <= rwl_s;
            RWLB      <= rwlb_s;
            Din       <= din_s;
        end
    end

    // Command operands latched at acceptance and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r     <= 2'b00;
            row_r    <= 4'd0;
            data_r   <= 16'h0000;
            rsp_data <= 64'h0;
        end else if (cntrl_reset) begin
            op_r     <= 2'b00;
            row_r    <= 4'd0;
            data_r   <= 16'h0000;
            rsp_data <= 64'h0;
        end else begin
            if (accept_s) begin
                op_r   <= cmd_op;
                row_r  <= cmd_row;
                data_r <= cmd_data;
            end
            if (state_r == ST_CAPTURE) begin
                rsp_data <= (op_r == OP_READ) ? {48'h0, sa_in} : adc_in;
            end
        end
    end

endmodule

// File: tb/tb_imc_array_sequencer.sv
// Self-checking bench for imc_array_sequencer: directed waveform checks plus a
// scoreboarded random command mix with per-cycle macro-safety checks.
module tb_imc_array_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, cntrl_reset, cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_row;
    logic [15:0] cmd_data;
    logic        PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, WE, EN, SAEN;
    logic [15:0] WWL, RWL, RWLB, Din;
    logic [63:0] adc_in;
    logic [15:0] sa_in;
    logic        rsp_valid, rsp_ready, busy;
    logic [63:0] rsp_data;
    logic [6:0]  ctrl;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    assign ctrl = {PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, WE, EN, SAEN};

    imc_array_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cntrl_reset(cntrl_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data),
        .PRE_SRAM(PRE_SRAM), .PRE_VLSA(PRE_VLSA), .PRE_CLSA(PRE_CLSA), .PRE_A(PRE_A),
        .WE(WE), .EN(EN), .SAEN(SAEN),
        .WWL(WWL), .RWL(RWL), .RWLB(RWLB), .Din(Din),
        .adc_in(adc_in), .sa_in(sa_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock and check macro safety rules in the new cycle
    task automatic tick();
        logic pre_any, wl_any;
        @(posedge clk);
        #1;
        pre_any = PRE_SRAM | PRE_VLSA | PRE_CLSA | PRE_A;
        wl_any  = (|WWL) | (|RWL) | (|RWLB);
        check_val("pre_wl_excl", 64'(pre_any & wl_any), 64'd0);
        check_val("we_wwl_zero", 64'(WE & (WWL == 16'h0000)), 64'd0);
    endtask

    task automatic check_cycle(input string name, input int c, input logic [6:0] e_ctrl,
                               input logic [15:0] e_wwl, input logic [15:0] e_din,
                               input logic [15:0] e_rwl, input logic [15:0] e_rwlb,
                               input logic e_ready, input logic e_valid);
        check_val($sformatf("%s_c%0d_ctrl", name, c), 64'(ctrl), 64'(e_ctrl));
        check_val($sformatf("%s_c%0d_wwl", name, c), 64'(WWL), 64'(e_wwl));
        check_val($sformatf("%s_c%0d_din", name, c), 64'(Din), 64'(e_din));
        check_val($sformatf("%s_c%0d_rwl", name, c), 64'(RWL), 64'(e_rwl));
        check_val($sformatf("%s_c%0d_rwlb", name, c), 64'(RWLB), 64'(e_rwlb));
        check_val($sformatf("%s_c%0d_ready", name, c), 64'(cmd_ready), 64'(e_ready));
        check_val($sformatf("%s_c%0d_valid", name, c), 64'(rsp_valid), 64'(e_valid));
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] row, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 16'h0000;
    endtask

    int n_rsp = 0;

    // random rsp_ready, scoreboard pop on each response handshake, then one clock
    task automatic step_rand();
        logic [63:0] e;
        rsp_ready = ($urandom_range(0, 3) != 0);
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                check_val("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("rnd_rsp_data", rsp_data, e);
            end
        end
        tick();
    endtask

    initial begin
        int seen;
        int n_exp;
        int guard;
        logic [1:0]  op;
        logic [63:0] a;
        logic [15:0] s;

        reset_n = 1'b0; cntrl_reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_row = 4'd0; cmd_data = 16'h0000; adc_in = 64'h0; sa_in = 16'h0; rsp_ready = 1'b0;
        tick(); tick();
        check_val("rst_ready_low", 64'(cmd_ready), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rsp_data", rsp_data, 64'd0);
        check_val("rst_ctrl", 64'(ctrl), 64'd0);
        reset_n = 1'b1;
        tick();
        check_val("rst_ready_high", 64'(cmd_ready), 64'd1);

        // WRITE row 3
        issue(2'b01, 4'd3, 16'hA5A5);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 2)      check_cycle("wr", c, 7'b1000000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
            else if (c <= 4) check_cycle("wr", c, 7'b0000100, 16'h0008, 16'hA5A5, 16'h0, 16'h0, 1'b0, 1'b0);
            else             check_cycle("wr", c, 7'b0000000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
            if (c < 5) tick();
        end

        // COMPUTE: adc_in carries the target value only on the capture cycle
        adc_in = 64'hFFFF_0000_FFFF_0000;
        issue(2'b10, 4'd7, 16'h00FF);
        for (int c = 1; c <= 7; c++) begin
            adc_in = (c == 6) ? 64'h0123_4567_89AB_CDEF : 64'hFFFF_0000_FFFF_0000;
            if (c <= 2)      check_cycle("cmp", c, 7'b1111000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
            else if (c <= 4) check_cycle("cmp", c, 7'b0000010, 16'h0, 16'h0, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
            else if (c == 5) check_cycle("cmp", c, 7'b0000011, 16'h0, 16'h0, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
            else if (c == 6) check_cycle("cmp", c, 7'b0000000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
            else             check_cycle("cmp", c, 7'b0000000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (c < 7) tick();
        end
        check_val("cmp_rsp_data", rsp_data, 64'h0123_4567_89AB_CDEF);
        rsp_ready = 1'b1;
        tick();
        check_val("cmp_c8_valid", 64'(rsp_valid), 64'd0);
        check_val("cmp_c8_ready", 64'(cmd_ready), 64'd1);
        check_val("cmp_c8_busy", 64'(busy), 64'd0);
        rsp_ready = 1'b0;

        // READ row 15 with a stalled consumer
        sa_in = 16'hBEEF;
        issue(2'b11, 4'd15, 16'h1234);
        for (int c = 1; c <= 10; c++) begin
            if (c >= 7) sa_in = 16'h0BAD;
            if (c <= 2)      check_cycle("rd", c, 7'b1111000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
            else if (c <= 4) check_cycle("rd", c, 7'b0000010, 16'h0, 16'h0, 16'h8000, 16'h0, 1'b0, 1'b0);
            else if (c == 5) check_cycle("rd", c, 7'b0000011, 16'h0, 16'h0, 16'h8000, 16'h0, 1'b0, 1'b0);
            else if (c == 6) check_cycle("rd", c, 7'b0000000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
            else begin
                check_cycle("rd", c, 7'b0000000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
                check_val($sformatf("rd_c%0d_data", c), rsp_data, 64'h0000_0000_0000_BEEF);
            end
            tick();
        end
        check_val("rd_c11_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        tick();
        check_val("rd_idle_busy", 64'(busy), 64'd0);
        check_val("rd_idle_ready", 64'(cmd_ready), 64'd1);
        check_val("rd_idle_valid", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;

        // NOP
        issue(2'b00, 4'd1, 16'hFFFF);
        check_val("nop_busy", 64'(busy), 64'd0);
        check_val("nop_ready", 64'(cmd_ready), 64'd1);
        check_val("nop_ctrl", 64'(ctrl), 64'd0);

        // asynchronous reset in the middle of EVAL
        issue(2'b10, 4'd0, 16'h0F0F);
        tick(); tick();
        check_val("arst_pre_en", 64'(ctrl), 64'(7'b0000010));
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_ctrl", 64'(ctrl), 64'd0);
        check_val("arst_rwl", 64'(RWL), 64'd0);
        check_val("arst_rwlb", 64'(RWLB), 64'd0);
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_ready", 64'(cmd_ready), 64'd0);
        check_val("arst_rsp_data", rsp_data, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_val("arst_ready_after", 64'(cmd_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check_val("arst_no_rsp", 64'(seen), 64'd0);

        // synchronous clear beats a simultaneous command
        cntrl_reset = 1'b1;
        issue(2'b01, 4'd2, 16'h1111);
        cntrl_reset = 1'b0;
        check_val("clr_busy", 64'(busy), 64'd0);
        check_val("clr_ready", 64'(cmd_ready), 64'd1);
        check_val("clr_ctrl", 64'(ctrl), 64'd0);
        issue(2'b01, 4'd5, 16'h2222);
        check_val("clr_wr_pre", 64'(ctrl), 64'(7'b1000000));
        check_val("clr_wr_busy", 64'(busy), 64'd1);
        tick(); tick();
        check_cycle("clr_wr", 3, 7'b0000100, 16'h0020, 16'h2222, 16'h0, 16'h0, 1'b0, 1'b0);
        tick(); tick();
        check_val("clr_wr_done", 64'(cmd_ready), 64'd1);

        // synchronous clear discards a pending result
        adc_in = 64'h5555_AAAA_5555_AAAA;
        issue(2'b10, 4'd0, 16'h0001);
        for (int c = 2; c <= 7; c++) tick();
        check_val("clr_pend_valid", 64'(rsp_valid), 64'd1);
        cntrl_reset = 1'b1;
        tick();
        cntrl_reset = 1'b0;
        check_val("clr_pend_valid_gone", 64'(rsp_valid), 64'd0);
        check_val("clr_pend_data", rsp_data, 64'd0);
        check_val("clr_pend_ready", 64'(cmd_ready), 64'd1);

        // random command mix against the scoreboard
        n_exp = 0;
        for (int i = 0; i < 200; i++) begin
            guard = 0;
            while (!cmd_ready && guard < 200) begin
                step_rand();
                guard++;
            end
            if (guard >= 200) check_val("rnd_ready_timeout", 64'd0, 64'd1);
            op = 2'($urandom_range(0, 3));
            a  = {$urandom(), $urandom()};
            s  = 16'($urandom());
            adc_in = a;
            sa_in  = s;
            if (op == 2'b10) begin
                exp_q.push_back(a);
                n_exp++;
            end else if (op == 2'b11) begin
                exp_q.push_back({48'h0, s});
                n_exp++;
            end
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_row   = 4'($urandom_range(0, 15));
            cmd_data  = 16'($urandom());
            step_rand();
            cmd_valid = 1'b0;
        end
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 200) begin
            step_rand();
            guard++;
        end
        for (int i = 0; i < 5; i++) step_rand();
        check_val("rnd_sb_empty", 64'(exp_q.size()), 64'd0);
        check_val("rnd_rsp_count", 64'(n_rsp), 64'(n_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imc_array_sequencer.md
# imc_array_sequencer

Phase sequencer for the 16x16 in-memory-compute SRAM macro (`Integrated_bitcell_with_dummy_cells`). It sits between the `top` control FSM and the macro and turns one-cycle commands into timed control waveforms:
- precharge, write-wordline and write-enable for row writes
- read-wordline, sense-amp and ADC enable for compute and row reads

It captures the macro's ADC or sense-amp result and returns it through a valid/ready response port.

## Interface
Parameters:
- PRE_CYC, 2, precharge phase length in cycles (1..15)
- EVAL_CYC, 2, read-wordline evaluate phase length (1..15)
- SA_CYC, 1, sense/ADC phase length (1..15)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cntrl_reset  in  1  synchronous clear, active-high; same effect as reset at the next edge
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts a command (IDLE only)
- cmd_op  in  2  00 NOP, 01 WRITE row, 10 COMPUTE, 11 READ row
- cmd_row  in  4  target row for WRITE/READ; ignored for COMPUTE
- cmd_data  in  16  WRITE: row data; COMPUTE: input vector
- PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, WE, EN, SAEN  out  1 each  macro controls
- WWL, RWL, RWLB, Din  out  16 each  macro wordlines and write data
- adc_in  in  64  macro ADC outputs, ADC k at [4k+3:4k]
- sa_in  in  16  macro SA_OUT
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  64  captured result
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, PRE, WRITE, EVAL, SENSE, CAPTURE, RESP.
- Command handshake: accepted on an edge where cmd_valid & cmd_ready. cmd_row and cmd_data are latched at acceptance and hold for the whole operation.
- NOP: accepted, stays IDLE, no output activity.
- WRITE: IDLE→PRE→WRITE→IDLE.
  - PRE: PRE_SRAM=1.
  - WRITE (2 cycles): WWL=onehot(row), WE=1, Din=data.
  - No response is produced.
- COMPUTE: IDLE→PRE→EVAL→SENSE→CAPTURE→RESP→IDLE.
  - PRE: PRE_SRAM=PRE_VLSA=PRE_CLSA=PRE_A=1.
  - EVAL: RWL=data, RWLB=~data, EN=1.
  - SENSE: RWL/RWLB/EN held, SAEN=1.
  - CAPTURE: rsp_data<=adc_in.
- READ: same path as COMPUTE, except RWL=onehot(row), RWLB=0, and CAPTURE loads rsp_data<={48'b0, sa_in}.
- Phase counter counts down from N-1 and the state advances when it reaches 0.
- All macro outputs are registered Moore decodes of state, with no combinational input-to-output path.
- In states where a control is not listed, that control is 0 and its buses are 16'h0000. Din is 0 outside WRITE.
- Wordlines and precharge are never active in the same cycle. WE is only active while WWL is nonzero.
- RESP: rsp_valid=1 and rsp_data is stable until rsp_ready. Handshake edge → IDLE.
- cmd_ready is 0 in RESP, so a new command cannot overtake a pending result.
- Reset or cntrl_reset during any state:
  - state → IDLE
  - all outputs → 0, including rsp_valid, and rsp_data → 0
  - any in-flight operation and pending result are discarded
- cntrl_reset and cmd_valid in the same cycle: the clear wins and the command is not accepted.

## Timing
- Reset values: cmd_ready=1 (0 while reset_n low), busy=0, rsp_valid=0, rsp_data=0, all macro controls 0.
- Cycle numbering: acceptance edge is cycle 0, P=PRE_CYC, E=EVAL_CYC, S=SA_CYC.
- WRITE:
  - PRE in cycles 1..P
  - WRITE in P+1..P+2
  - cmd_ready=1 at P+3 (defaults: cycle 5)
- COMPUTE/READ:
  - PRE in 1..P
  - EVAL in P+1..P+E
  - SENSE in P+E+1..P+E+S
  - CAPTURE at P+E+S+1, sampling adc_in/sa_in on that cycle's closing edge
  - rsp_valid from P+E+S+2 (defaults: cycle 7)
- With rsp_ready held high, rsp_valid lasts 1 cycle and cmd_ready returns the next cycle.
- Back-to-back throughput with defaults: WRITE every 5 cycles, COMPUTE every 8 cycles.

## Test plan
- Reset, then WRITE row=3 data=16'hA5A5 → PRE_SRAM=1 in cycles 1–2; WWL=16'h0008, WE=1, Din=16'hA5A5 in cycles 3–4; cmd_ready=1 at cycle 5; no rsp_valid.
- COMPUTE data=16'h00FF with adc_in model returning 64'h0123_4567_89AB_CDEF → during EVAL, RWL=16'h00FF, RWLB=16'hFF00, EN=1; SAEN=1 at cycle 5 only; rsp_valid at cycle 7 with rsp_data=64'h0123_4567_89AB_CDEF.
- READ row=15 with sa_in=16'hBEEF and rsp_ready held 0 for 4 cycles → RWL=16'h8000, RWLB=0; rsp_valid and rsp_data=64'h0000_0000_0000_BEEF stable for 4 cycles; cmd_ready=0 throughout; IDLE one cycle after rsp_ready.
- Pull reset_n low asynchronously mid-EVAL of a COMPUTE → all outputs 0 immediately, with no clock edge; after release, cmd_ready=1 and no rsp_valid appears.
- cntrl_reset=1 together with cmd_valid=1, op=WRITE → command not accepted and no WE pulse; next cycle a WRITE is accepted normally.
- Random mix of 200 commands with random rsp_ready, checked against a reference model → never precharge and wordline in the same cycle, never WE with WWL=0, every COMPUTE/READ yields exactly one response.
